// File: rtl/button_conditioner_pkg.sv
// Shared types and helpers for the push-button conditioner.
// Holds the per-channel FSM state encoding and the ms-to-cycles conversion.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } btn_state_e;

    // Convert a duration in ms to clk cycles; never returns less than 1.
    function automatic int ms_to_cyc(input int freq_hz, input int ms);
        int cyc;
        cyc = freq_hz / 1000 * ms;
        return (cyc < 1) ? 1 : cyc;
    endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM, hold and repeat timers.
// Ports: clk, rst (async high), raw pin in; press/long one-cycle pulses, level out.
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEB_CYC   = 4,
    parameter int LONG_CYC  = 20,
    parameter int REP_CYC   = 5,
    parameter bit REPEAT_EN = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press,
    output logic long,
    output logic level
);

    localparam int DW = $clog2(DEB_CYC) + 1;
    localparam int HW = $clog2(LONG_CYC) + 1;
    localparam int RW = $clog2(REP_CYC) + 1;

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REP_CYC - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    btn_state_e    state_q, state_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          press_q, press_d;
    logic          long_q, long_d;

    logic s;
    logic held;
    logic accept;
    logic hold_hit;
    logic rep_hit;

    assign s     = sync2_q;
    assign held  = (state_q == PRESSED) || (state_q == DEB_RELEASE);
    assign level = held;
    assign press = press_q;
    assign long  = long_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            state_q    <= IDLE;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            press_q    <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            press_q    <= press_d;
            long_q     <= long_d;
        end
    end

    always_comb begin
        sync1_d    = raw;
        sync2_d    = sync1_q;
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = '0;
        accept     = 1'b0;
        hold_hit   = 1'b0;
        rep_hit    = 1'b0;

        // Hold time keeps running through release bouncing.
        if (held) begin
            if (hold_cnt_q != HOLD_MAX) begin
                hold_cnt_d = hold_cnt_q + HW'(1);
            end
            hold_hit = (hold_cnt_q == HOLD_LAST);
        end

        unique case (state_q)
            IDLE: begin
                if (s) begin
                    state_d   = DEB_PRESS;
                    deb_cnt_d = '0;
                end
            end
            DEB_PRESS: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d    = PRESSED;
                    accept     = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d   = DEB_RELEASE;
                    deb_cnt_d = '0;
                end
                // Repeat period starts counting once the hold saturates.
                if (hold_cnt_q == HOLD_MAX) begin
                    if (rep_cnt_q == REP_LAST) begin
                        rep_hit = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + RW'(1);
                    end
                end
            end
            DEB_RELEASE: begin
                if (s) begin
                    state_d = PRESSED;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        press_d = accept | (REPEAT_EN & (hold_hit | rep_hit));
        long_d  = hold_hit;
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the three raw pet-control buttons into press / long-press pulses.
// Ports: clk, rst, {menu,next,select}_raw in; *_button, select_long pulses, btn_level.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int CLOCK_FREQ    = 125_000_000,
    parameter int DEBOUNCE_MS   = 10,
    parameter int LONG_PRESS_MS = 1000,
    parameter int REPEAT_MS     = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       menu_raw,
    input  logic       next_raw,
    input  logic       select_raw,
    output logic       menu_button,
    output logic       next_button,
    output logic       select_button,
    output logic       select_long,
    output logic [2:0] btn_level
);

    localparam int DEB_CYC  = ms_to_cyc(CLOCK_FREQ, DEBOUNCE_MS);
    localparam int LONG_CYC = ms_to_cyc(CLOCK_FREQ, LONG_PRESS_MS);
    localparam int REP_CYC  = ms_to_cyc(CLOCK_FREQ, REPEAT_MS);

    logic menu_long_unused;
    logic next_long_unused;
    logic menu_level;
    logic next_level;
    logic select_level;

    button_channel #(
        .DEB_CYC   (DEB_CYC),
        .LONG_CYC  (LONG_CYC),
        .REP_CYC   (REP_CYC),
        .REPEAT_EN (1'b0)
    ) u_menu (
        .clk   (clk),
        .rst   (rst),
        .raw   (menu_raw),
        .press (menu_button),
        .long  (menu_long_unused),
        .level (menu_level)
    );

    // Only next auto-repeats; its long-hold pulse folds into next_button.
    button_channel #(
        .DEB_CYC   (DEB_CYC),
        .LONG_CYC  (LONG_CYC),
        .REP_CYC   (REP_CYC),
        .REPEAT_EN (1'b1)
    ) u_next (
        .clk   (clk),
        .rst   (rst),
        .raw   (next_raw),
        .press (next_button),
        .long  (next_long_unused),
        .level (next_level)
    );

    button_channel #(
        .DEB_CYC   (DEB_CYC),
        .LONG_CYC  (LONG_CYC),
        .REP_CYC   (REP_CYC),
        .REPEAT_EN (1'b0)
    ) u_select (
        .clk   (clk),
        .rst   (rst),
        .raw   (select_raw),
        .press (select_button),
        .long  (select_long),
        .level (select_level)
    );

    assign btn_level = {select_level, next_level, menu_level};

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: run-length reference model feeds
// an expected-output queue; a monitor pops and compares every cycle.
module tb_button_conditioner;

    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       menu_raw = 1'b0;
    logic       next_raw = 1'b0;
    logic       select_raw = 1'b0;
    logic       menu_button;
    logic       next_button;
    logic       select_button;
    logic       select_long;
    logic [2:0] btn_level;

    always #5 clk = ~clk;

    button_conditioner #(
        .CLOCK_FREQ    (1000),
        .DEBOUNCE_MS   (4),
        .LONG_PRESS_MS (20),
        .REPEAT_MS     (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .menu_raw      (menu_raw),
        .next_raw      (next_raw),
        .select_raw    (select_raw),
        .menu_button   (menu_button),
        .next_button   (next_button),
        .select_button (select_button),
        .select_long   (select_long),
        .btn_level     (btn_level)
    );

    typedef struct {
        string name;
        int    kind;
        int    exp;
    } req_t;

    logic [6:0] exp_q[$];
    req_t       req_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int cnt[4] = '{default: 0};
    int last_m = -1;
    int last_s = -2;

    // Reference model: a button is accepted (or released) once the
    // synchronised pin has disagreed with the accepted level for DEB+1
    // sampled edges in a row. Hold time is edges since acceptance.
    bit m_s1[3];
    bit m_s2[3];
    bit m_lev[3];
    int m_cnt[3];
    int m_hold[3];
    int m_tmr[3];
    logic [2:0] m_raw, m_prs, m_lng, m_rep, m_lv;

    always @(posedge clk) begin
        m_raw = {select_raw, next_raw, menu_raw};
        if (rst) begin
            for (int c = 0; c < 3; c++) begin
                m_s1[c] = 0; m_s2[c] = 0; m_lev[c] = 0;
                m_cnt[c] = 0; m_hold[c] = 0; m_tmr[c] = 0;
            end
            exp_q.push_back(7'd0);
        end else begin
            for (int c = 0; c < 3; c++) begin
                bit s, pl;
                int pc, ph;
                s = m_s2[c]; pl = m_lev[c];
                pc = m_cnt[c]; ph = m_hold[c];
                m_prs[c] = 0; m_lng[c] = 0; m_rep[c] = 0;
                if (pl) begin
                    m_lng[c] = (ph == LONG - 1);
                    m_hold[c] = (ph < LONG) ? ph + 1 : LONG;
                    if (ph == LONG && pc == 0) begin
                        m_tmr[c]++;
                        if (m_tmr[c] == REP) begin
                            m_rep[c] = 1;
                            m_tmr[c] = 0;
                        end
                    end else begin
                        m_tmr[c] = 0;
                    end
                end
                if (s != pl) begin
                    m_cnt[c] = pc + 1;
                    if (m_cnt[c] == DEB + 1) begin
                        m_lev[c] = s;
                        m_cnt[c] = 0;
                        if (s) begin
                            m_prs[c] = 1;
                            m_hold[c] = 0;
                        end
                    end
                end else begin
                    m_cnt[c] = 0;
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = m_raw[c];
                m_lv[c] = m_lev[c];
            end
            exp_q.push_back({m_lng[2], m_prs[2],
                             m_prs[1] | m_lng[1] | m_rep[1],
                             m_prs[0], m_lv});
        end
    end

    logic [6:0] mon_got, mon_exp;
    req_t       mon_r;
    int         mon_v;

    always begin
        @(posedge clk or posedge rst);
        #1;
        mon_got = {select_long, select_button, next_button,
                   menu_button, btn_level};
        if (clk == 1'b0) begin
            checks++;
            if (mon_got != 7'd0) begin
                errors++;
                $display("FAIL rst_async got=%b want=0000000", mon_got);
            end
        end else begin
            cyc++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty cyc=%0d got=%b want=entry", cyc, mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL cyc%0d {sl,sb,nb,mb,lvl} got=%b want=%b",
                             cyc, mon_got, mon_exp);
                end
            end
            if (menu_button)   begin cnt[0]++; last_m = cyc; end
            if (next_button)   cnt[1]++;
            if (select_button) begin cnt[2]++; last_s = cyc; end
            if (select_long)   cnt[3]++;
            while (req_q.size() > 0) begin
                mon_r = req_q.pop_front();
                mon_v = (mon_r.kind == 4) ? int'(last_m == last_s)
                                          : cnt[mon_r.kind];
                checks++;
                if (mon_v != mon_r.exp) begin
                    errors++;
                    $display("FAIL %s got=%0d want=%0d",
                             mon_r.name, mon_v, mon_r.exp);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req(input string name, input int kind, input int exp);
        req_t r;
        r.name = name; r.kind = kind; r.exp = exp;
        req_q.push_back(r);
    endtask

    int b[4];
    int tmr[3];
    logic [2:0] rv;

    initial begin
        tick(3);
        rst = 1'b0;
        tick(5);

        b = cnt;
        menu_raw = 1'b1; tick(10);
        menu_raw = 1'b0; tick(15);
        req("menu_press", 0, b[0] + 1);
        req("menu_no_next", 1, b[1]);
        req("menu_no_sel", 2, b[2]);

        b = cnt;
        next_raw = 1'b1; tick(1);
        next_raw = 1'b0; tick(1);
        next_raw = 1'b1; tick(1);
        next_raw = 1'b0; tick(1);
        next_raw = 1'b1; tick(3);
        next_raw = 1'b0; tick(15);
        req("bounce_next", 1, b[1]);

        b = cnt;
        next_raw = 1'b1; tick(40);
        next_raw = 1'b0; tick(15);
        req("hold_next_pulses", 1, b[1] + 5);

        b = cnt;
        select_raw = 1'b1; tick(30);
        select_raw = 1'b0; tick(15);
        req("sel30_press", 2, b[2] + 1);
        req("sel30_long", 3, b[3] + 1);

        b = cnt;
        select_raw = 1'b1; tick(15);
        select_raw = 1'b0; tick(15);
        req("sel15_press", 2, b[2] + 1);
        req("sel15_no_long", 3, b[3]);

        b = cnt;
        next_raw = 1'b1; tick(17);
        rst = 1'b1; tick(2);
        rst = 1'b0; tick(8);
        next_raw = 1'b0; tick(15);
        req("rst_fresh_next", 1, b[1] + 2);

        b = cnt;
        menu_raw = 1'b1; select_raw = 1'b1; tick(10);
        menu_raw = 1'b0; select_raw = 1'b0; tick(1);
        menu_raw = 1'b1; select_raw = 1'b1; tick(2);
        menu_raw = 1'b0; select_raw = 1'b0; tick(15);
        req("simul_menu", 0, b[0] + 1);
        req("simul_sel", 2, b[2] + 1);
        req("simul_same_cycle", 4, 1);

        rv = 3'b000;
        for (int c = 0; c < 3; c++) tmr[c] = $urandom_range(1, 30);
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < 3; c++) begin
                tmr[c]--;
                if (tmr[c] <= 0) begin
                    rv[c] = ~rv[c];
                    tmr[c] = ($urandom_range(0, 3) == 0)
                           ? $urandom_range(1, 3)
                           : $urandom_range(4, 40);
                end
            end
            {select_raw, next_raw, menu_raw} = rv;
            tick(1);
        end
        {select_raw, next_raw, menu_raw} = 3'b000;
        tick(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
